// File: rtl/sc_pkg.sv
// Shared types, constants and LFSR step function for the SC evaluation sequencer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sc_seq_state_e;

    localparam int         SC_DATA_W = 8;
    localparam logic [7:0] SC_SEED   = 8'hA5;
    // Feedback taps s[7], s[2], s[1], s[0]: polynomial x^8+x^7+x^2+x+1, period 255.
    localparam logic [7:0] SC_TAPS   = 8'b1000_0111;

    // One right-shift step: new MSB is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {^(s & SC_TAPS), s[7:1]};
    endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// Loadable 8-bit Fibonacci LFSR; load has priority over shift-enable.
// Latency: load or shift takes effect on the next clock edge.
// Backpressure: none; advances whenever en_i is high.
module sc_lfsr8
    import sc_pkg::*;
#(
    parameter logic [7:0] RST_VAL = SC_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [7:0] seed_i,
    output logic [7:0] q_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next state: load a fresh seed, otherwise step when enabled.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = seed_i;
        end else if (en_i) begin
            q_d = lfsr_next(q_q);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sc_eval_sequencer.sv
// Sequences one SC evaluation: drives LFSR/operand/feedback, counts ones over STREAM_LEN cycles.
// Latency: accept edge E0, res_valid after edge E0+STREAM_LEN; job-to-job >= STREAM_LEN+2 cycles.
// Backpressure: start_ready only in IDLE; result held in DONE until res_ready.
// Option SC_SEED_CHAIN_EN: each job seeds from the final LFSR state of the last completed job.
module sc_eval_sequencer
    import sc_pkg::*;
#(
    parameter int                DATA_W     = SC_DATA_W,
    parameter int                STREAM_LEN = 255,
    parameter logic [DATA_W-1:0] SEED       = SC_SEED,
    localparam int               CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] job_seed,
    input  logic [DATA_W-1:0] job_bin,
    input  logic              abort_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy_o,
    output logic [DATA_W-1:0] sc_state_o,
    output logic [DATA_W-1:0] sc_bin_o,
    output logic              sc_fb_o,
    input  logic              sc_fb_i,
    input  logic              sc_bit_i
);

    sc_seq_state_e     state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic              fb_q, fb_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;

    logic              lfsr_load;
    logic              lfsr_en;
    logic [DATA_W-1:0] lfsr_seed;
    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] base_seed;

`ifdef SC_SEED_CHAIN_EN
    logic [DATA_W-1:0] chain_q, chain_d;
    logic              chain_vld_q, chain_vld_d;
`endif

    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    assign base_seed = (job_seed == '0) ? SEED : job_seed;

    sc_lfsr8 #(
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .en_i   (lfsr_en),
        .seed_i (lfsr_seed),
        .q_o    (lfsr_q)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        fb_d        = fb_q;
        count_d     = count_q;
        cyc_d       = cyc_q;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;
        lfsr_seed   = base_seed;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy_o      = 1'b0;
`ifdef SC_SEED_CHAIN_EN
        chain_d     = chain_q;
        chain_vld_d = chain_vld_q;
        if (chain_vld_q) begin
            lfsr_seed = chain_q;
        end
`endif
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    lfsr_load = 1'b1;
                    bin_d     = job_bin;
                    fb_d      = 1'b0;
                    count_d   = '0;
                    cyc_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                // Abort wins over the final-cycle transition; partial count is dropped.
                if (abort_i) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + {{(CNT_W-1){1'b0}}, sc_bit_i};
                    fb_d    = sc_fb_i;
                    cyc_d   = cyc_q + 1'b1;
                    lfsr_en = 1'b1;
                    if (cyc_q == CNT_W'(STREAM_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
`ifdef SC_SEED_CHAIN_EN
                    chain_d     = lfsr_q;
                    chain_vld_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            fb_q    <= 1'b0;
            count_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            fb_q    <= fb_d;
            count_q <= count_d;
            cyc_q   <= cyc_d;
        end
    end

`ifdef SC_SEED_CHAIN_EN
    // Chain seed register; only completed jobs update it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q     <= SEED;
            chain_vld_q <= 1'b0;
        end else begin
            chain_q     <= chain_d;
            chain_vld_q <= chain_vld_d;
        end
    end
`endif

    assign res_count  = count_q;
    assign sc_state_o = lfsr_q;
    assign sc_bin_o   = bin_q;
    assign sc_fb_o    = fb_q;

endmodule

// File: tb/tb_sc_eval_sequencer.sv
// Self-checking bench for sc_eval_sequencer: job-level model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: exercised via res_ready holds and start_valid held through a job.
module tb_sc_eval_sequencer;

    localparam int LEN    = 255;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       start_valid = 1'b0;
    logic       abort_i     = 1'b0;
    logic       res_ready   = 1'b1;
    logic       sc_fb_i     = 1'b0;
    logic       sc_bit_i    = 1'b0;
    logic [7:0] job_seed    = 8'h00;
    logic [7:0] job_bin     = 8'h00;
    logic       start_ready, res_valid, busy_o, sc_fb_o;
    logic [7:0] res_count, sc_state_o, sc_bin_o;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: bit=0, 1: bit=1, 2: toggle from first RUN cycle, 3: state<bin

    // Job-level model state
    int         m_ph    = P_IDLE;
    logic [7:0] m_lfsr  = 8'hA5;
    logic [7:0] m_bin   = 8'h00;
    logic [7:0] m_last  = 8'h00;
    logic [7:0] m_sd    = 8'h00;
    logic       m_fb    = 1'b0;
    int         m_cnt   = 0;
    int         m_k     = 0;
    bit         m_ok    = 1'b0;
    bit         m_chain = 1'b0;

    logic [7:0] st_hist [5];

    sc_eval_sequencer #(.STREAM_LEN(LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .job_seed    (job_seed),
        .job_bin     (job_bin),
        .abort_i     (abort_i),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .busy_o      (busy_o),
        .sc_state_o  (sc_state_o),
        .sc_bin_o    (sc_bin_o),
        .sc_fb_o     (sc_fb_o),
        .sc_fb_i     (sc_fb_i),
        .sc_bit_i    (sc_bit_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] next8(input logic [7:0] s);
        logic [7:0] r;
        r[6:0] = s[7:1];
        r[7]   = s[7] ^ s[2] ^ s[1] ^ s[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Circuit stand-in: output bit and feedback bit change on the falling edge.
    always @(negedge clk) begin
        case (mode)
            0:       sc_bit_i = 1'b0;
            1:       sc_bit_i = 1'b1;
            2:       sc_bit_i = ((m_k % 2) == 0);
            default: sc_bit_i = (m_lfsr < m_bin);
        endcase
        sc_fb_i = 1'($urandom_range(0, 1));
    end

    // Behavioural model: advances one clock edge at a time using the pre-edge inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_lfsr = 8'hA5; m_bin = 8'h00; m_fb = 1'b0;
            m_cnt = 0; m_k = 0; m_chain = 1'b0; m_ok = 1'b1;
        end else begin
            case (m_ph)
                P_IDLE: if (start_valid) begin
                    m_sd = (job_seed == 8'h00) ? 8'hA5 : job_seed;
`ifdef SC_SEED_CHAIN_EN
                    if (m_chain) m_sd = m_last;
`endif
                    m_lfsr = m_sd; m_bin = job_bin; m_fb = 1'b0;
                    m_cnt = 0; m_k = 0; m_ph = P_RUN;
                end
                P_RUN: begin
                    if (abort_i) begin
                        m_ph = P_IDLE;
                    end else begin
                        m_cnt  = m_cnt + int'(sc_bit_i);
                        m_fb   = sc_fb_i;
                        m_lfsr = next8(m_lfsr);
                        m_k    = m_k + 1;
                        if (m_k == LEN) m_ph = P_DONE;
                    end
                end
                default: if (res_ready) begin
                    m_ph = P_IDLE; m_last = m_lfsr; m_chain = 1'b1;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            chk("start_ready", 32'(start_ready), 32'(m_ph == P_IDLE));
            chk("busy_o",      32'(busy_o),      32'(m_ph != P_IDLE));
            chk("res_valid",   32'(res_valid),   32'(m_ph == P_DONE));
            if (m_ph != P_IDLE) begin
                chk("sc_state_o", 32'(sc_state_o), 32'(m_lfsr));
                chk("sc_bin_o",   32'(sc_bin_o),   32'(m_bin));
                chk("sc_fb_o",    32'(sc_fb_o),    32'(m_fb));
            end
            if (m_ph == P_DONE) chk("res_count", 32'(res_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start_valid = 1'b0; abort_i = 1'b0; res_ready = 1'b1;
        tick();
        chk("rst sc_state_o",  32'(sc_state_o),  32'h A5);
        chk("rst sc_bin_o",    32'(sc_bin_o),    32'h00);
        chk("rst sc_fb_o",     32'(sc_fb_o),     32'h0);
        chk("rst res_valid",   32'(res_valid),   32'h0);
        chk("rst res_count",   32'(res_count),   32'h00);
        chk("rst busy_o",      32'(busy_o),      32'h0);
        chk("rst start_ready", 32'(start_ready), 32'h1);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_job(input logic [7:0] seed, input logic [7:0] bin);
        job_seed = seed; job_bin = bin; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic wait_res(output int edges);
        edges = 0;
        while (!res_valid && edges < LEN + 50) begin
            if (edges < 5) st_hist[edges] = sc_state_o;
            tick();
            edges++;
        end
        if (!res_valid) chk("res_valid timeout", 32'(res_valid), 32'h1);
    endtask

    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (m_k != target && n < LEN + 50) begin
            tick();
            n++;
        end
        chk("run cycle reached", 32'(m_k), 32'(target));
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        tick();
        chk("idle after handshake", 32'(start_ready), 32'h1);
        chk("valid drop after handshake", 32'(res_valid), 32'h0);
    endtask

    initial begin
        int e;
        logic [7:0] held;

        // Reset state
        do_reset();

        // Seed 01 with constant-one bit: full stream, LFSR returns to seed
        mode = 1;
        start_job(8'h01, 8'h00);
        wait_res(e);
        chk("t1 latency edges", 32'(e), 32'd255);
        chk("t1 st0", 32'(st_hist[0]), 32'h01);
        chk("t1 st1", 32'(st_hist[1]), 32'h80);
        chk("t1 st2", 32'(st_hist[2]), 32'hC0);
        chk("t1 st3", 32'(st_hist[3]), 32'hE0);
        chk("t1 st4", 32'(st_hist[4]), 32'hF0);
        chk("t1 count", 32'(res_count), 32'd255);
        chk("t1 final state", 32'(sc_state_o), 32'h01);
        finish_job();

        // Toggle, zero and comparator patterns
        mode = 2;
        start_job(8'h37, 8'h00);
        wait_res(e);
        chk("t2 toggle count", 32'(res_count), 32'd128);
        finish_job();
        mode = 0;
        start_job(8'h37, 8'h00);
        wait_res(e);
        chk("t2 zero count", 32'(res_count), 32'd0);
        finish_job();
        mode = 3;
        start_job(8'h5A, 8'h80);
        wait_res(e);
        chk("t2 compare count", 32'(res_count), 32'd127);
        finish_job();

        // Zero seed substitution; start_valid held through RUN and DONE
        do_reset();
        mode = 1;
        job_seed = 8'h00; job_bin = 8'h33; start_valid = 1'b1;
        tick();
        chk("t3 zero seed -> A5", 32'(sc_state_o), 32'hA5);
        chk("t3 bin loaded", 32'(sc_bin_o), 32'h33);
        res_ready = 1'b0;
        wait_res(e);
        repeat (3) tick();
        chk("t3 no accept in DONE", 32'(start_ready), 32'h0);
        chk("t3 still busy", 32'(busy_o), 32'h1);
        start_valid = 1'b0;
        finish_job();

        // Abort at RUN cycle 10, then a clean job
        mode = 1;
        start_job(8'h11, 8'h00);
        wait_k(10);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t4 abort busy", 32'(busy_o), 32'h0);
        chk("t4 abort ready", 32'(start_ready), 32'h1);
        repeat (5) begin
            tick();
            chk("t4 no result", 32'(res_valid), 32'h0);
        end
        start_job(8'h22, 8'h00);
        wait_res(e);
        chk("t4 post-abort count", 32'(res_count), 32'd255);
        finish_job();
        // Abort on the last RUN cycle
        start_job(8'h33, 8'h00);
        wait_k(254);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t4 last-cycle abort valid", 32'(res_valid), 32'h0);
        chk("t4 last-cycle abort busy", 32'(busy_o), 32'h0);

        // Result held under backpressure; abort ignored in DONE
        mode = 2;
        res_ready = 1'b0;
        start_job(8'h44, 8'h00);
        wait_res(e);
        held = res_count;
        chk("t5 held count", 32'(held), 32'd128);
        for (int i = 0; i < 20; i++) begin
            abort_i = (i == 5);
            tick();
            chk("t5 valid stable", 32'(res_valid), 32'h1);
            chk("t5 count stable", 32'(res_count), 32'(held));
        end
        abort_i = 1'b0;
        finish_job();
        // Reset mid-RUN
        mode = 1;
        start_job(8'h55, 8'h00);
        wait_k(50);
        do_reset();

        // Back-to-back jobs: seed of the second job
        mode = 0;
        start_job(8'h5A, 8'h00);
        wait_res(e);
        finish_job();
        start_job(8'hC3, 8'h00);
`ifdef SC_SEED_CHAIN_EN
        chk("t6 chained seed", 32'(sc_state_o), 32'h5A);
`else
        chk("t6 job seed", 32'(sc_state_o), 32'hC3);
`endif
        wait_res(e);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
